// File: rtl/mem_port_arb_pkg.sv
// mem_port_arb_pkg
// Shared definitions for the memory port arbiter:
//   - state_t : FSM state encoding (IDLE / REQ / RESP, 2 bits)
//   - clog2   : ceiling log2, sizes the grant index and the round-robin pointer
package mem_port_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Smallest r with 2**r >= n; callers always pass n >= 2.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the NUM_CH sram-like master channels and the single sram-like
// memory port of the arbiter.
//   Master side : m_req, m_wr, m_sel, m_addr, m_wdata (channel i at slice i)
//                 m_addr_ok, m_data_ok (per channel), m_rdata (shared)
//   Memory side : s_req, s_wr, s_sel, s_addr, s_wdata
//                 s_addr_ok, s_data_ok, s_rdata
// Modports:
//   slave  - used by the arbiter (accepts master requests, drives memory side)
//   master - used by the environment (masters plus memory model)
interface mem_port_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  logic [NUM_CH-1:0]        m_req;
  logic [NUM_CH-1:0]        m_wr;
  logic [NUM_CH*SEL_W-1:0]  m_sel;
  logic [NUM_CH*ADDR_W-1:0] m_addr;
  logic [NUM_CH*DATA_W-1:0] m_wdata;
  logic [NUM_CH-1:0]        m_addr_ok;
  logic [NUM_CH-1:0]        m_data_ok;
  logic [DATA_W-1:0]        m_rdata;

  logic                     s_req;
  logic                     s_wr;
  logic [SEL_W-1:0]         s_sel;
  logic [ADDR_W-1:0]        s_addr;
  logic [DATA_W-1:0]        s_wdata;
  logic                     s_addr_ok;
  logic                     s_data_ok;
  logic [DATA_W-1:0]        s_rdata;

  modport slave (
    input  m_req, m_wr, m_sel, m_addr, m_wdata,
    output m_addr_ok, m_data_ok, m_rdata,
    output s_req, s_wr, s_sel, s_addr, s_wdata,
    input  s_addr_ok, s_data_ok, s_rdata
  );

  modport master (
    output m_req, m_wr, m_sel, m_addr, m_wdata,
    input  m_addr_ok, m_data_ok, m_rdata,
    input  s_req, s_wr, s_sel, s_addr, s_wdata,
    output s_addr_ok, s_data_ok, s_rdata
  );

endinterface

// File: rtl/mem_port_arb_pick.sv
// mem_port_arb_pick
// Purely combinational channel picker. Scans the request vector starting at
// index 'start' and wrapping past NUM_CH-1 back to 0; the first set bit wins.
//   req   in  NUM_CH  request vector
//   start in  IDX_W   first index examined (0 gives fixed priority)
//   idx   out IDX_W   winning channel (0 when nothing requests)
//   valid out 1       at least one request is set
module mem_port_arb_pick
  import mem_port_arb_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [clog2(NUM_CH)-1:0]  start,
  output logic [clog2(NUM_CH)-1:0]  idx,
  output logic                      valid
);
  localparam int IDX_W = clog2(NUM_CH);

  // One spare bit so start+i can exceed NUM_CH-1 before the wrap is applied.
  logic [IDX_W:0] pos;

  // Walk the channels in search order; the first requester found wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pos = {1'b0, start} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(NUM_CH)) pos = pos - (IDX_W+1)'(NUM_CH);
      if (!valid && req[pos[IDX_W-1:0]]) begin
        valid = 1'b1;
        idx   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates NUM_CH sram-like master channels onto a single sram-like memory
// port, one transaction at a time, and routes each response back to the
// master that issued it.
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   synchronous active-high reset
//   bus  slave modport of mem_port_arbiter_if (master channels + memory port)
//   busy out  high whenever the FSM is not IDLE
// Build option:
//   MEM_PORT_ARB_RR_EN - round-robin arbitration with a last-grant pointer;
//                        when undefined, lowest channel index wins.
module mem_port_arbiter
  import mem_port_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic                busy
);
  localparam int SEL_W = DATA_W / 8;
  localparam int IDX_W = clog2(NUM_CH);

  state_t             state, next_state;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   start_idx;
  logic               pick_valid;
  logic               take;

  logic               wr_q;
  logic [SEL_W-1:0]   sel_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;

  logic               wr_in;
  logic [SEL_W-1:0]   sel_in;
  logic [ADDR_W-1:0]  addr_in;
  logic [DATA_W-1:0]  wdata_in;

  logic [NUM_CH-1:0]  addr_ok;
  logic [NUM_CH-1:0]  data_ok;
  logic               s_req_c;

`ifdef MEM_PORT_ARB_RR_EN
  logic [IDX_W-1:0]   lg;

  // Last-grant pointer: starts at the top channel so the first search begins at 0.
  always_ff @(posedge clk) begin
    if (rst)       lg <= IDX_W'(NUM_CH-1);
    else if (take) lg <= pick_idx;
  end

  assign start_idx = (lg == IDX_W'(NUM_CH-1)) ? '0 : lg + IDX_W'(1);
`else
  assign start_idx = '0;
`endif

  mem_port_arb_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req   (bus.m_req),
    .start (start_idx),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Select the winning channel's payload so it can be latched on the grant.
  always_comb begin
    wr_in    = 1'b0;
    sel_in   = '0;
    addr_in  = '0;
    wdata_in = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        wr_in    = bus.m_wr[i];
        sel_in   = bus.m_sel[i*SEL_W +: SEL_W];
        addr_in  = bus.m_addr[i*ADDR_W +: ADDR_W];
        wdata_in = bus.m_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // State, grant and latched request. The latched copy is what drives the
  // memory side, so masters are free to change their inputs after addr_ok.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      grant   <= '0;
      wr_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= next_state;
      if (take) begin
        grant   <= pick_idx;
        wr_q    <= wr_in;
        sel_q   <= sel_in;
        addr_q  <= addr_in;
        wdata_q <= wdata_in;
      end
    end
  end

  // Next state and handshake pulses. Pulses are suppressed while reset is
  // high so an abandoned transaction never reports completion; a data_ok
  // arriving in IDLE is a stale response and is simply ignored.
  always_comb begin
    next_state = state;
    addr_ok    = '0;
    data_ok    = '0;
    s_req_c    = 1'b0;
    take       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          take              = 1'b1;
          addr_ok[pick_idx] = 1'b1;
          next_state        = ST_REQ;
        end
      end
      ST_REQ: begin
        s_req_c = 1'b1;
        if (bus.s_addr_ok) begin
          if (bus.s_data_ok) begin
            data_ok[grant] = 1'b1;
            next_state     = ST_IDLE;
          end else begin
            next_state = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (bus.s_data_ok) begin
          data_ok[grant] = 1'b1;
          next_state     = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    if (rst) begin
      addr_ok = '0;
      data_ok = '0;
      s_req_c = 1'b0;
      take    = 1'b0;
    end
  end

  assign bus.m_addr_ok = addr_ok;
  assign bus.m_data_ok = data_ok;
  assign bus.m_rdata   = (|data_ok) ? bus.s_rdata : '0;
  assign bus.s_req     = s_req_c;
  assign bus.s_wr      = wr_q;
  assign bus.s_sel     = sel_q;
  assign bus.s_addr    = addr_q;
  assign bus.s_wdata   = wdata_q;
  assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter (3 channels, 32-bit address/data).
// A directed vector table covers single read, byte write with changing master
// inputs, zero-latency slave and reset with a stale response; hand sequences
// cover arbitration order; a randomized run is compared against a
// transaction-level reference model. Honours MEM_PORT_ARB_RR_EN.
module tb_mem_port_arbiter;
  localparam int NUM_CH = 3;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;
`ifdef MEM_PORT_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic busy;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst;
    logic [2:0]  req;
    bit          chg;
    bit          aok;
    bit          dok;
    logic [31:0] rdata;
    logic [2:0]  e_aok;
    logic [2:0]  e_dok;
    bit          e_sreq;
    bit          e_busy;
    bit          chk_rd;
    int          pay;   // -1 unchecked, 0 zeros, 1 ch1 request, 2 ch0 request
  } vec_t;

  vec_t tbl[$];

  task automatic applyStimulus(input vec_t v);
    rst            = v.rst;
    bus.m_req      = v.req;
    bus.m_wr       = {1'b0, 1'b0, !v.chg};
    bus.m_sel      = {4'h3, 4'hF, (v.chg ? 4'b0001 : 4'b1000)};
    bus.m_addr     = {32'h0000_3000, 32'h0000_1000, (v.chg ? 32'hFFFF_FFFF : 32'h0000_2003)};
    bus.m_wdata    = {32'h0, 32'h1111_1111, (v.chg ? 32'h5555_5555 : 32'hAA00_0000)};
    bus.s_addr_ok  = v.aok;
    bus.s_data_ok  = v.dok;
    bus.s_rdata    = v.rdata;
  endtask

  // ---------------- master / memory model state ----------------
  bit          pend   [NUM_CH];
  logic        wr_a   [NUM_CH];
  logic [3:0]  sel_a  [NUM_CH];
  logic [31:0] addr_a [NUM_CH];
  logic [31:0] wdata_a[NUM_CH];
  bit          keep_req = 1'b0;

  int          owner = -1;
  bit          accepted = 1'b0;
  int          lg_m = NUM_CH - 1;
  logic        exp_wr;
  logic [3:0]  exp_sel;
  logic [31:0] exp_addr, exp_wdata;

  int glog[$];
  int gcyc[$];
  int cyc = 0;

  // Reference arbitration: lowest index, or first requester after the last grant.
  function automatic int policy(input logic [NUM_CH-1:0] r, input int last);
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
      c = RR_MODE ? (last + 1 + k) % NUM_CH : k;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic driveMasters();
    for (int c = 0; c < NUM_CH; c++) begin
      bus.m_req[c]                  = pend[c];
      bus.m_wr[c]                   = wr_a[c];
      bus.m_sel[c*SEL_W +: SEL_W]   = sel_a[c];
      bus.m_addr[c*ADDR_W +: ADDR_W] = addr_a[c];
      bus.m_wdata[c*DATA_W +: DATA_W] = wdata_a[c];
    end
  endtask

  // One clock of model-checked operation with the given reset and slave inputs.
  task automatic runCycle(input bit r, input bit aok, input bit dok, input logic [31:0] rd);
    logic [NUM_CH-1:0] reqv, e_aok, e_dok;
    bit e_sreq, e_busy, rd_chk;
    int g;
    @(posedge clk);
    #1;
    cyc++;
    rst           = r;
    bus.s_addr_ok = aok;
    bus.s_data_ok = dok;
    bus.s_rdata   = rd;
    driveMasters();
    for (int c = 0; c < NUM_CH; c++) reqv[c] = pend[c];
    e_aok = '0; e_dok = '0; e_sreq = 1'b0; rd_chk = 1'b0; g = -1;
    e_busy = (owner >= 0);
    if (!r) begin
      if (owner < 0) begin
        g = policy(reqv, lg_m);
        if (g >= 0) e_aok[g] = 1'b1;
      end else if (!accepted) begin
        e_sreq = 1'b1;
        if (aok && dok) begin e_dok[owner] = 1'b1; rd_chk = !exp_wr; end
      end else if (dok) begin
        e_dok[owner] = 1'b1; rd_chk = !exp_wr;
      end
    end
    @(negedge clk);
    checkOutput("addr_ok", 64'(bus.m_addr_ok), 64'(e_aok));
    checkOutput("data_ok", 64'(bus.m_data_ok), 64'(e_dok));
    checkOutput("s_req", 64'(bus.s_req), 64'(e_sreq));
    checkOutput("busy", 64'(busy), 64'(e_busy));
    if (e_sreq) begin
      checkOutput("s_addr", 64'(bus.s_addr), 64'(exp_addr));
      checkOutput("s_sel", 64'(bus.s_sel), 64'(exp_sel));
      checkOutput("s_wdata", 64'(bus.s_wdata), 64'(exp_wdata));
      checkOutput("s_wr", 64'(bus.s_wr), 64'(exp_wr));
    end
    if (rd_chk) checkOutput("m_rdata", 64'(bus.m_rdata), 64'(rd));
    for (int c = 0; c < NUM_CH; c++)
      if (bus.m_addr_ok[c] === 1'b1) begin glog.push_back(c); gcyc.push_back(cyc); end
    if (r) begin
      owner = -1; accepted = 1'b0; lg_m = NUM_CH - 1;
    end else if (owner < 0) begin
      if (g >= 0) begin
        owner = g; accepted = 1'b0; lg_m = g;
        exp_wr = wr_a[g]; exp_sel = sel_a[g]; exp_addr = addr_a[g]; exp_wdata = wdata_a[g];
        if (!keep_req) pend[g] = 1'b0;
      end
    end else if (!accepted) begin
      if (aok) begin
        if (dok) owner = -1;
        else     accepted = 1'b1;
      end
    end else if (dok) begin
      owner = -1;
    end
  endtask

  task automatic setChannel(input int c, input logic w, input logic [3:0] s,
                            input logic [31:0] a, input logic [31:0] d);
    wr_a[c] = w; sel_a[c] = s; addr_a[c] = a; wdata_a[c] = d;
  endtask

  initial begin
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_sel;
    logic        e_wr;
    int          exp_seq[4];

    rst = 1'b1;
    bus.m_req = '0; bus.m_wr = '0; bus.m_sel = '0; bus.m_addr = '0; bus.m_wdata = '0;
    bus.s_addr_ok = 1'b0; bus.s_data_ok = 1'b0; bus.s_rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pend[c] = 1'b0;
      setChannel(c, 1'b0, 4'h0, 32'h0, 32'h0);
    end
    repeat (2) @(posedge clk);

    //            rst  req     chg  aok  dok  rdata         e_aok   e_dok   sreq busy rd  pay
    tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0,         3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0,         3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0,         3'b000, 3'b000, 1'b1, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0,         3'b000, 3'b000, 1'b1, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0,         3'b000, 3'b000, 1'b1, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF,  3'b000, 3'b010, 1'b0, 1'b1, 1'b1, -1});
    tbl.push_back('{1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 32'h0,         3'b001, 3'b000, 1'b0, 1'b0, 1'b0, -1});
    tbl.push_back('{1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0,         3'b000, 3'b000, 1'b1, 1'b1, 1'b0, 2});
    tbl.push_back('{1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 32'h0,         3'b000, 3'b000, 1'b1, 1'b1, 1'b0, 2});
    tbl.push_back('{1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 32'h12345678,  3'b000, 3'b001, 1'b0, 1'b1, 1'b0, -1});
    tbl.push_back('{1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0,         3'b010, 3'b000, 1'b0, 1'b0, 1'b0, -1});
    tbl.push_back('{1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 32'hCAFEF00D,  3'b000, 3'b010, 1'b1, 1'b1, 1'b1, 1});
    tbl.push_back('{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0,         3'b000, 3'b000, 1'b0, 1'b0, 1'b0, -1});
    tbl.push_back('{1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 32'h0,         3'b001, 3'b000, 1'b0, 1'b0, 1'b0, -1});
    tbl.push_back('{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0,         3'b000, 3'b000, 1'b1, 1'b1, 1'b0, 2});
    tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0,         3'b000, 3'b000, 1'b0, 1'b1, 1'b0, -1});
    tbl.push_back('{1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 32'h0BADF00D,  3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0,         3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      applyStimulus(tbl[i]);
      @(negedge clk);
      checkOutput($sformatf("row%0d_addr_ok", i), 64'(bus.m_addr_ok), 64'(tbl[i].e_aok));
      checkOutput($sformatf("row%0d_data_ok", i), 64'(bus.m_data_ok), 64'(tbl[i].e_dok));
      checkOutput($sformatf("row%0d_s_req", i), 64'(bus.s_req), 64'(tbl[i].e_sreq));
      checkOutput($sformatf("row%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
      if (tbl[i].chk_rd)
        checkOutput($sformatf("row%0d_m_rdata", i), 64'(bus.m_rdata), 64'(tbl[i].rdata));
      if (tbl[i].pay >= 0) begin
        case (tbl[i].pay)
          1:       begin e_addr = 32'h0000_1000; e_sel = 4'hF;    e_wdata = 32'h1111_1111; e_wr = 1'b0; end
          2:       begin e_addr = 32'h0000_2003; e_sel = 4'b1000; e_wdata = 32'hAA00_0000; e_wr = 1'b1; end
          default: begin e_addr = 32'h0;         e_sel = 4'h0;    e_wdata = 32'h0;         e_wr = 1'b0; end
        endcase
        checkOutput($sformatf("row%0d_s_addr", i), 64'(bus.s_addr), 64'(e_addr));
        checkOutput($sformatf("row%0d_s_sel", i), 64'(bus.s_sel), 64'(e_sel));
        checkOutput($sformatf("row%0d_s_wdata", i), 64'(bus.s_wdata), 64'(e_wdata));
        checkOutput($sformatf("row%0d_s_wr", i), 64'(bus.s_wr), 64'(e_wr));
      end
    end
    $display("[TB] vector table done");

    // Simultaneous ch0/ch1: ch0 first, ch1 (held) in the IDLE after ch0 completes.
    runCycle(1'b1, 1'b0, 1'b0, 32'h0);
    runCycle(1'b1, 1'b0, 1'b0, 32'h0);
    setChannel(0, 1'b0, 4'hF, 32'h0000_4000, 32'h0);
    setChannel(1, 1'b1, 4'h3, 32'h0000_5002, 32'h0000_BEEF);
    pend[0] = 1'b1; pend[1] = 1'b1;
    glog.delete(); gcyc.delete();
    runCycle(1'b0, 1'b0, 1'b0, 32'h0);
    runCycle(1'b0, 1'b1, 1'b0, 32'h0);
    runCycle(1'b0, 1'b0, 1'b1, 32'h7777_0000);
    runCycle(1'b0, 1'b0, 1'b0, 32'h0);
    runCycle(1'b0, 1'b1, 1'b1, 32'h0);
    runCycle(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("prio_grant_count", 64'(glog.size()), 64'd2);
    if (glog.size() >= 2) begin
      checkOutput("prio_first", 64'(glog[0]), 64'd0);
      checkOutput("prio_second", 64'(glog[1]), 64'd1);
      checkOutput("prio_spacing", 64'(gcyc[1] - gcyc[0]), 64'd3);
    end

    // Both requests held continuously for four transactions.
    keep_req = 1'b1;
    pend[0] = 1'b1; pend[1] = 1'b1;
    glog.delete(); gcyc.delete();
    for (int t = 0; t < 4; t++) begin
      runCycle(1'b0, 1'b0, 1'b0, 32'h0);
      runCycle(1'b0, 1'b1, 1'b0, 32'h0);
      runCycle(1'b0, 1'b0, 1'b1, $urandom);
    end
    keep_req = 1'b0;
    for (int c = 0; c < NUM_CH; c++) pend[c] = 1'b0;
    exp_seq = RR_MODE ? '{0, 1, 0, 1} : '{0, 0, 0, 0};
    checkOutput("held_grant_count", 64'(glog.size()), 64'd4);
    if (glog.size() >= 4)
      for (int t = 0; t < 4; t++)
        checkOutput($sformatf("held_grant%0d", t), 64'(glog[t]), 64'(exp_seq[t]));
    $display("[TB] arbitration sequences done");

    // Randomized traffic against the reference model.
    glog.delete(); gcyc.delete();
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!pend[c]) begin
          setChannel(c, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom);
          if ($urandom_range(0, 3) == 0) pend[c] = 1'b1;
        end
      end
      runCycle($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 2) == 0, $urandom);
    end
    checkOutput("random_activity", 64'(glog.size() > 100), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
